hazard_scoreboard: RTL and testbench

Parametrised decode-stage hazard unit for the 5-stage RISC-V pipeline. It generalises load-use detection to any number of source operands and any result latency, up to MAX_LAT cycles. A per-register pending-latency counter (scoreboard) stalls the ID instruction while a source, or a write-after-write destination, still has an unfinished producer in flight. It drives the PC/IF-ID write enables and the ID/EX bubble, and keeps a stall-cycle performance counter.

---
 rtl/hazard_scoreboard_pkg.sv | 15 +
 rtl/hazard_pend_counter.sv | 31 +++
 rtl/hazard_scoreboard.sv | 118 +++++++++++
 tb/tb_hazard_scoreboard.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/hazard_scoreboard_pkg.sv
// Shared types and latency classes for the decode-stage hazard scoreboard.
package hazard_scoreboard_pkg;

    typedef logic [4:0] reg_addr_t;

    // Default deepest result latency; the top module may override it.
    localparam int DEFAULT_MAX_LAT = 4;

    // Result latency classes as issued from ID.
    localparam int LAT_ALU  = 0;
    localparam int LAT_LOAD = 1;
    localparam int LAT_MUL  = 2;
    localparam int LAT_DIV  = DEFAULT_MAX_LAT;

endpackage

// File: rtl/hazard_pend_counter.sv
// Pending-latency down-counter for one architectural register.
// Clear has priority, then hold (memory freeze), then load, then decrement.
module hazard_pend_counter #(
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hold,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_reg;

    // Count down toward zero; a new producer overwrites the remaining latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg <= '0;
        end else if (!hold) begin
            if (load) begin
                count_reg <= load_val;
            end else if (count_reg != '0) begin
                count_reg <= count_reg - 1'b1;
            end
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/hazard_scoreboard.sv
// Decode-stage hazard unit: per-register pending-latency scoreboard that
// stalls ID on RAW/WAW conflicts and counts stall cycles.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int NREGS   = 32,
    parameter int NUM_SRC = 2,
    parameter int MAX_LAT = DEFAULT_MAX_LAT,
    localparam int CNT_W  = $clog2(MAX_LAT + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   id_valid,
    input  logic [NUM_SRC*5-1:0]   id_rs,
    input  logic [NUM_SRC-1:0]     id_rs_used,
    input  logic [4:0]             id_rd,
    input  logic                   id_wr_en,
    input  logic [CNT_W-1:0]       id_lat,
    input  logic                   flush,
    input  logic                   mem_stall,
    output logic                   pc_we,
    output logic                   ifid_we,
    output logic                   idex_bubble,
    output logic                   id_issue,
    output logic                   hazard,
    output logic [NREGS-1:0]       busy_mask,
    output logic [31:0]            stall_cycles
);

    localparam logic [CNT_W-1:0] MAX_LAT_C = CNT_W'(MAX_LAT);

    logic [CNT_W-1:0] pend [NREGS];
    logic [NREGS-1:0] busy_raw;
    logic [31:0]      busy_all;
    logic [CNT_W-1:0] rd_pend;
    logic [CNT_W-1:0] lat_eff;
    logic [NUM_SRC-1:0] raw_vec;
    logic             waw;
    logic             live;
    logic             hazard_int;
    logic             issue_wr;
    logic [31:0]      stall_cycles_reg;

    // x0 never has a producer in flight.
    assign pend[0]     = '0;
    assign busy_raw[0] = 1'b0;

    // Oversized latencies saturate at the deepest unit.
    assign lat_eff  = (id_lat > MAX_LAT_C) ? MAX_LAT_C : id_lat;
    assign issue_wr = id_issue && id_wr_en && (id_rd != '0) && (lat_eff != '0);

    genvar gi;
    generate
        for (gi = 1; gi < NREGS; gi++) begin : g_pend
            hazard_pend_counter #(
                .CNT_W(CNT_W)
            ) u_cnt (
                .clk      (clk),
                .rst      (rst),
                .hold     (mem_stall),
                .load     (issue_wr && (id_rd == reg_addr_t'(gi))),
                .load_val (lat_eff),
                .count    (pend[gi])
            );
            assign busy_raw[gi] = (pend[gi] != '0);
        end
    endgenerate

    // Zero-extend the busy vector so any 5-bit address can index it safely.
    always_comb begin
        busy_all = '0;
        busy_all[NREGS-1:0] = busy_raw;
    end

    // Remaining latency of the destination register, for the WAW check.
    always_comb begin
        rd_pend = '0;
        for (int r = 1; r < NREGS; r++) begin
            if (id_rd == reg_addr_t'(r)) begin
                rd_pend = pend[r];
            end
        end
    end

    generate
        for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
            assign raw_vec[gi] = id_rs_used[gi]
                              && (id_rs[gi*5 +: 5] != '0)
                              && busy_all[id_rs[gi*5 +: 5]];
        end
    endgenerate

    // A younger write may not land before an older one still in flight.
    assign waw = id_wr_en && (id_rd != '0) && (rd_pend > id_lat);

    // Flush kills the ID instruction, so it can neither stall nor issue.
    assign live       = !rst && id_valid && !flush;
    assign hazard_int = live && ((|raw_vec) || waw);

    assign hazard      = hazard_int;
    assign id_issue    = live && !hazard_int && !mem_stall;
    assign pc_we       = rst || (!hazard_int && !mem_stall);
    assign ifid_we     = pc_we;
    assign idex_bubble = !rst && (hazard_int || flush) && !mem_stall;
    assign busy_mask   = rst ? '0 : busy_raw;

    // Saturating count of cycles lost to scoreboard stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles_reg <= '0;
        end else if (hazard_int && !mem_stall && (stall_cycles_reg != '1)) begin
            stall_cycles_reg <= stall_cycles_reg + 32'd1;
        end
    end

    assign stall_cycles = stall_cycles_reg;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench: the driver predicts every cycle's outputs from a
// ready-time model and queues them; the monitor compares on the falling edge.
module tb_hazard_scoreboard;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [9:0]  id_rs;
    logic [1:0]  id_rs_used;
    logic [4:0]  id_rd;
    logic        id_wr_en;
    logic [2:0]  id_lat;
    logic        flush;
    logic        mem_stall;
    logic        pc_we;
    logic        ifid_we;
    logic        idex_bubble;
    logic        id_issue;
    logic        hazard;
    logic [31:0] busy_mask;
    logic [31:0] stall_cycles;

    always #5 clk = ~clk;

    hazard_scoreboard dut (
        .clk          (clk),
        .rst          (rst),
        .id_valid     (id_valid),
        .id_rs        (id_rs),
        .id_rs_used   (id_rs_used),
        .id_rd        (id_rd),
        .id_wr_en     (id_wr_en),
        .id_lat       (id_lat),
        .flush        (flush),
        .mem_stall    (mem_stall),
        .pc_we        (pc_we),
        .ifid_we      (ifid_we),
        .idex_bubble  (idex_bubble),
        .id_issue     (id_issue),
        .hazard       (hazard),
        .busy_mask    (busy_mask),
        .stall_cycles (stall_cycles)
    );

    typedef struct packed {
        logic        hazard;
        logic        issue;
        logic        pc_we;
        logic        ifid_we;
        logic        bubble;
        logic [31:0] busy;
        logic [31:0] stall;
    } exp_t;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;
    bit   driver_done = 0;

    // Model: a register is free once the count of unfrozen clock edges
    // reaches its ready time; remaining latency = ready - tick, floored at 0.
    int          tick = 0;
    int          ready_at [32];
    longint      stall_m = 0;

    function automatic int pend_m(input int r);
        int d;
        if (r == 0) return 0;
        d = ready_at[r] - tick;
        return (d > 0) ? d : 0;
    endfunction

    // Apply one cycle of ID inputs, queue the prediction, then clock it.
    task automatic cycle(input bit v, input int rs0, input int rs1, input bit [1:0] used,
                         input int rd, input bit wr, input int lat,
                         input bit fl, input bit ms, input bit r);
        exp_t e;
        bit   raw, waw, hz, iss;
        int   leff;
        rst = r; id_valid = v; id_rs = {rs1[4:0], rs0[4:0]}; id_rs_used = used;
        id_rd = rd[4:0]; id_wr_en = wr; id_lat = lat[2:0]; flush = fl; mem_stall = ms;

        raw = (used[0] && rs0 != 0 && pend_m(rs0) != 0) ||
              (used[1] && rs1 != 0 && pend_m(rs1) != 0);
        waw = wr && rd != 0 && pend_m(rd) > lat;
        hz  = !r && v && !fl && (raw || waw);
        iss = !r && v && !fl && !hz && !ms;
        e.hazard  = hz;
        e.issue   = iss;
        e.pc_we   = r ? 1'b1 : (!hz && !ms);
        e.ifid_we = e.pc_we;
        e.bubble  = r ? 1'b0 : ((hz || fl) && !ms);
        e.busy    = '0;
        if (!r) for (int k = 1; k < 32; k++) e.busy[k] = (pend_m(k) != 0);
        e.stall   = stall_m[31:0];
        exp_q.push_back(e);

        @(posedge clk);
        leff = (lat > 4) ? 4 : lat;
        if (r) begin
            for (int k = 0; k < 32; k++) ready_at[k] = 0;
            stall_m = 0;
        end else if (!ms) begin
            if (hz && stall_m < 64'hFFFF_FFFF) stall_m++;
            tick++;
            if (iss && wr && rd != 0 && leff != 0) ready_at[rd] = tick + leff;
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: every cycle the DUT presents a full set of outputs.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            vectors++;
            if (hazard !== e.hazard) begin
                miscompares++;
                $display("FAIL hazard @%0t: got %b want %b", $time, hazard, e.hazard);
            end
            if (id_issue !== e.issue) begin
                miscompares++;
                $display("FAIL id_issue @%0t: got %b want %b", $time, id_issue, e.issue);
            end
            if (pc_we !== e.pc_we) begin
                miscompares++;
                $display("FAIL pc_we @%0t: got %b want %b", $time, pc_we, e.pc_we);
            end
            if (ifid_we !== e.ifid_we) begin
                miscompares++;
                $display("FAIL ifid_we @%0t: got %b want %b", $time, ifid_we, e.ifid_we);
            end
            if (idex_bubble !== e.bubble) begin
                miscompares++;
                $display("FAIL idex_bubble @%0t: got %b want %b", $time, idex_bubble, e.bubble);
            end
            if (busy_mask !== e.busy) begin
                miscompares++;
                $display("FAIL busy_mask @%0t: got %h want %h", $time, busy_mask, e.busy);
            end
            if (stall_cycles !== e.stall) begin
                miscompares++;
                $display("FAIL stall_cycles @%0t: got %0d want %0d", $time, stall_cycles, e.stall);
            end
        end
    end

    initial begin
        for (int k = 0; k < 32; k++) ready_at[k] = 0;
        rst = 1; id_valid = 0; id_rs = '0; id_rs_used = '0; id_rd = '0;
        id_wr_en = 0; id_lat = '0; flush = 0; mem_stall = 0;
        @(posedge clk); #1;
        cycle(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 1);
        cycle(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 1);

        // Load x5 then add x6,x5,x1: one stall cycle, then issue.
        cycle(1, 0, 0, 2'b00, 5, 1, 1, 0, 0, 0);
        cycle(1, 5, 1, 2'b11, 6, 1, 0, 0, 0, 0);
        cycle(1, 5, 1, 2'b11, 6, 1, 0, 0, 0, 0);
        idle(2);
        // Mul x7 (lat 3) with a dependent held in ID.
        cycle(1, 0, 0, 2'b00, 7, 1, 3, 0, 0, 0);
        for (int k = 0; k < 4; k++) cycle(1, 7, 0, 2'b01, 10, 1, 0, 0, 0, 0);
        idle(1);
        // Load into x0, then a reader of x0: never tracked.
        cycle(1, 0, 0, 2'b00, 0, 1, 1, 0, 0, 0);
        cycle(1, 0, 0, 2'b11, 11, 1, 0, 0, 0, 0);
        idle(1);
        // WAW: lat-3 write of x8 followed by a lat-1 write of x8.
        cycle(1, 0, 0, 2'b00, 8, 1, 3, 0, 0, 0);
        for (int k = 0; k < 3; k++) cycle(1, 1, 2, 2'b11, 8, 1, 1, 0, 0, 0);
        idle(2);
        // Load x5 with dependent frozen by mem_stall for two cycles.
        cycle(1, 0, 0, 2'b00, 5, 1, 1, 0, 0, 0);
        cycle(1, 5, 0, 2'b01, 12, 1, 0, 0, 1, 0);
        cycle(1, 5, 0, 2'b01, 12, 1, 0, 0, 1, 0);
        cycle(1, 5, 0, 2'b01, 12, 1, 0, 0, 0, 0);
        cycle(1, 5, 0, 2'b01, 12, 1, 0, 0, 0, 0);
        // Reset with x9 pending, then a reader of x9.
        cycle(1, 0, 0, 2'b00, 9, 1, 2, 0, 0, 0);
        cycle(1, 9, 0, 2'b01, 13, 1, 0, 0, 0, 1);
        cycle(1, 9, 0, 2'b01, 13, 1, 0, 0, 0, 0);
        // Flush over a RAW hazard, and a latency beyond the deepest unit.
        cycle(1, 0, 0, 2'b00, 14, 1, 7, 0, 0, 0);
        cycle(1, 14, 0, 2'b01, 15, 1, 0, 1, 0, 0);
        for (int k = 0; k < 5; k++) cycle(1, 14, 0, 2'b01, 15, 1, 0, 0, 0, 0);

        // Random traffic over a small register window to force conflicts.
        for (int n = 0; n < 3000; n++) begin
            cycle($urandom_range(99) < 85,
                  int'($urandom_range(9)), int'($urandom_range(9)),
                  2'($urandom_range(3)), int'($urandom_range(9)),
                  $urandom_range(99) < 70, int'($urandom_range(7)),
                  $urandom_range(99) < 8, $urandom_range(99) < 15,
                  $urandom_range(999) < 15);
        end
        driver_done = 1;
    end

    // Drain the scoreboard with a bounded wait, then summarise.
    initial begin
        wait (driver_done);
        for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(posedge clk);
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d entries left want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
